// File: rtl/lutram_capture_buffer_if.sv
// lutram_capture_buffer_if: control, sample and read-port bundle for the capture buffer
interface lutram_capture_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              in_arm;
  logic              in_abort;
  logic [DATA_W-1:0] in_sample;
  logic              in_sample_valid;
  logic              in_trig;
  logic [ADDR_W-1:0] in_pretrig;
  logic              in_rd_en;
  logic [ADDR_W-1:0] in_rd_addr;
  logic [DATA_W-1:0] out_rd_data;
  logic              out_rd_valid;
  logic              out_busy;
  logic              out_triggered;
  logic              out_done;
  modport master (
    output in_arm, in_abort, in_sample, in_sample_valid, in_trig, in_pretrig, in_rd_en, in_rd_addr,
    input  out_rd_data, out_rd_valid, out_busy, out_triggered, out_done
  );
  modport slave (
    input  in_arm, in_abort, in_sample, in_sample_valid, in_trig, in_pretrig, in_rd_en, in_rd_addr,
    output out_rd_data, out_rd_valid, out_busy, out_triggered, out_done
  );
endinterface

// File: rtl/lutram_capture_buffer.sv
// lutram_capture_buffer: circular pre/post-trigger sample capture in distributed RAM
module lutram_capture_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input logic                    in_clk,
  input logic                    in_rst_n,
  lutram_capture_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;
  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, p_lat, pre_cnt, trig_ptr, rd_idx;
  logic [ADDR_W:0]   post_cnt, post_len;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, triggered, done, we;
  assign post_len = (ADDR_W+1)'(DEPTH) - {1'b0, p_lat};
  assign we = bus.in_sample_valid && !bus.in_abort && !bus.in_arm && (state inside {FILL, ARMED, POST});
  // logical index 0 is the oldest sample, P_lat samples before the trigger
  assign rd_idx = trig_ptr - p_lat + bus.in_rd_addr;
  assign bus.out_busy = state inside {FILL, ARMED, POST};
  assign bus.out_rd_data = rd_data;
  assign bus.out_rd_valid = rd_valid;
  assign bus.out_triggered = triggered;
  assign bus.out_done = done;
  always_ff @(posedge in_clk)
    if (we) mem[wptr] <= bus.in_sample;
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      state <= IDLE;
      wptr <= '0;
      p_lat <= '0;
      pre_cnt <= '0;
      post_cnt <= '0;
      trig_ptr <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      triggered <= 1'b0;
      done <= 1'b0;
    end else begin
      rd_valid <= bus.in_rd_en && state == DONE;
      if (bus.in_rd_en && state == DONE) rd_data <= mem[rd_idx];
      if (bus.in_abort) begin
        state <= IDLE;
        triggered <= 1'b0;
        done <= 1'b0;
      end else if (bus.in_arm) begin
        state <= bus.in_pretrig != '0 ? FILL : ARMED;
        p_lat <= bus.in_pretrig;
        wptr <= '0;
        pre_cnt <= '0;
        post_cnt <= '0;
        triggered <= 1'b0;
        done <= 1'b0;
      end else if (bus.in_sample_valid) begin
        case (state)
          FILL: begin
            wptr <= wptr + ADDR_W'(1);
            pre_cnt <= pre_cnt + ADDR_W'(1);
            if (pre_cnt + ADDR_W'(1) == p_lat) state <= ARMED;
          end
          ARMED: begin
            wptr <= wptr + ADDR_W'(1);
            if (bus.in_trig) begin
              trig_ptr <= wptr;
              post_cnt <= (ADDR_W+1)'(1);
              triggered <= 1'b1;
              state <= post_len == (ADDR_W+1)'(1) ? DONE : POST;
              done <= post_len == (ADDR_W+1)'(1);
            end
          end
          POST: begin
            wptr <= wptr + ADDR_W'(1);
            post_cnt <= post_cnt + (ADDR_W+1)'(1);
            if (post_cnt + (ADDR_W+1)'(1) == post_len) begin
              state <= DONE;
              done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_lutram_capture_buffer.sv
// tb_lutram_capture_buffer: scoreboarded capture/readback scenarios for a 16-deep buffer
module tb_lutram_capture_buffer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  logic in_clk = 1'b0;
  logic in_rst_n = 1'b0;
  lutram_capture_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  lutram_capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (.in_clk(in_clk), .in_rst_n(in_rst_n), .bus(bus));
  always #5 in_clk = ~in_clk;
  typedef struct {logic [DW-1:0] d; int due;} rd_t;
  rd_t rd_q[$];
  rd_t mon_e;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;
  always @(posedge in_clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge in_clk)
    if (mon_on) begin
      if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
        mon_e = rd_q.pop_front();
        check("rd_valid", bus.out_rd_valid, 1);
        check("rd_data", bus.out_rd_data, mon_e.d);
      end else check("rd_idle", bus.out_rd_valid, 0);
    end
  task automatic step();
    @(posedge in_clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.in_arm = 0;
    bus.in_abort = 0;
    bus.in_sample = '0;
    bus.in_sample_valid = 0;
    bus.in_trig = 0;
    bus.in_pretrig = '0;
    bus.in_rd_en = 0;
    bus.in_rd_addr = '0;
  endtask
  task automatic arm(input int p);
    bus.in_arm = 1;
    bus.in_pretrig = AW'(p);
    bus.in_sample_valid = 1;
    bus.in_sample = 8'hAA;
    bus.in_trig = 1;
    step();
    idle_inputs();
    check("busy_after_arm", bus.out_busy, 1);
    check("done_clr_on_arm", bus.out_done, 0);
  endtask
  // drives valid samples base+k; stops after stop_n samples or when the capture should be done
  task automatic capture(input int p, input int trig_at, input int trig2, input int base, input bit toggle, input int stop_n);
    int k, cy, last;
    bit v;
    k = 0;
    cy = 0;
    last = trig_at + DEPTH - p - 1;
    arm(p);
    while (k != stop_n) begin
      if (cy > 400) begin
        check("capture_timeout", 0, 1);
        break;
      end
      v = !toggle || cy[0] == 1'b0;
      bus.in_sample_valid = v;
      bus.in_sample = v ? DW'(base + k) : 8'hEE;
      bus.in_trig = v ? (k == trig_at || k == trig2) : 1'b1;
      step();
      cy++;
      if (v) begin
        if (k == trig_at) check("triggered", bus.out_triggered, 1);
        if (k < trig_at) check("not_triggered", bus.out_triggered, 0);
        if (k == last) begin
          check("done", bus.out_done, 1);
          check("busy_at_done", bus.out_busy, 0);
          break;
        end
        check("not_done", bus.out_done, 0);
        check("busy", bus.out_busy, 1);
        k++;
      end
    end
    idle_inputs();
  endtask
  task automatic read_all(input int p, input int trig_val);
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_rd_en = 1;
      bus.in_rd_addr = AW'(i);
      rd_q.push_back('{d: DW'(trig_val - p + i), due: cyc + 1});
      step();
    end
    bus.in_rd_addr = AW'(p);
    rd_q.push_back('{d: DW'(trig_val), due: cyc + 1});
    step();
    bus.in_rd_en = 0;
    step();
    step();
  endtask
  initial begin
    idle_inputs();
    repeat (3) step();
    in_rst_n = 1;
    step();
    check("rst_busy", bus.out_busy, 0);
    check("rst_triggered", bus.out_triggered, 0);
    check("rst_done", bus.out_done, 0);
    check("rst_rd_valid", bus.out_rd_valid, 0);
    check("rst_rd_data", bus.out_rd_data, 0);
    mon_on = 1;
    capture(4, 10, -1, 0, 0, -1);
    read_all(4, 10);
    capture(4, 10, -1, 0, 0, 14);
    #1 in_rst_n = 0;
    #1;
    check("rst_mid_busy", bus.out_busy, 0);
    check("rst_mid_triggered", bus.out_triggered, 0);
    check("rst_mid_done", bus.out_done, 0);
    check("rst_mid_rd_valid", bus.out_rd_valid, 0);
    check("rst_mid_rd_data", bus.out_rd_data, 0);
    step();
    in_rst_n = 1;
    bus.in_rd_en = 1;
    step();
    bus.in_rd_en = 0;
    check("rd_after_reset", bus.out_rd_valid, 0);
    capture(8, 20, 3, 0, 0, -1);
    read_all(8, 20);
    capture(0, 0, -1, 'h55, 0, -1);
    read_all(0, 'h55);
    capture(15, 40, -1, 0, 1, -1);
    read_all(15, 40);
    capture(4, 10, -1, 0, 0, 14);
    bus.in_abort = 1;
    step();
    bus.in_abort = 0;
    check("abort_busy", bus.out_busy, 0);
    check("abort_done", bus.out_done, 0);
    check("abort_triggered", bus.out_triggered, 0);
    bus.in_rd_en = 1;
    bus.in_arm = 1;
    bus.in_abort = 1;
    bus.in_pretrig = AW'(3);
    step();
    idle_inputs();
    check("arm_abort_busy", bus.out_busy, 0);
    bus.in_sample_valid = 1;
    bus.in_trig = 1;
    repeat (3) step();
    idle_inputs();
    check("arm_abort_stays_idle", bus.out_busy, 0);
    check("arm_abort_no_trigger", bus.out_triggered, 0);
    capture(2, 5, -1, 0, 0, -1);
    read_all(2, 5);
    check("rd_queue_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lutram_capture_buffer.md
# lutram_capture_buffer

Parametrised distributed-RAM capture buffer for the logic analyzer sample path; the generalised successor of the fixed 8x128 LUTRAM. It continuously records qualified samples into a circular buffer, holds a programmable number of pre-trigger samples, and stops after filling the remaining depth with post-trigger samples. After capture it exposes a registered read port addressed by logical index, where 0 is the oldest sample.

## Interface
- DATA_W, 8, sample width in bits
- ADDR_W, 7, address width; depth DEPTH = 2^ADDR_W
- in_clk  input  1  sole clock, all logic on rising edge
- in_rst_n  input  1  asynchronous, active-low reset
- in_arm  input  1  one-cycle pulse: latch in_pretrig, start a new capture
- in_abort  input  1  one-cycle pulse: cancel capture, return to IDLE
- in_sample  input  DATA_W  sample data
- in_sample_valid  input  1  sample qualifier; only valid samples are written or evaluated
- in_trig  input  1  trigger condition for the sample presented this cycle
- in_pretrig  input  ADDR_W  pre-trigger sample count P, 0..DEPTH-1
- in_rd_en  input  1  read strobe, honoured only in DONE
- in_rd_addr  input  ADDR_W  logical read index, 0 = oldest
- out_rd_data  output  DATA_W  registered read data
- out_rd_valid  output  1  out_rd_data valid this cycle
- out_busy  output  1  state is FILL, ARMED or POST
- out_triggered  output  1  trigger accepted in the current capture
- out_done  output  1  capture complete, buffer readable

## Operation
- RAM uses the DEPTH x DATA_W distributed style: synchronous write, combinational read, output register. RAM contents are not reset.
- Registers: state, wptr (ADDR_W), P_lat, pre_cnt, post_cnt (ADDR_W+1 bits), trig_ptr.
- States:
  - IDLE:
    - in_arm → latch P_lat = in_pretrig, wptr = 0, pre_cnt = 0, clear out_triggered and out_done.
    - Next state is FILL if P > 0, else ARMED.
  - FILL:
    - Each valid sample is written at wptr, then wptr++ and pre_cnt++.
    - in_trig is ignored.
    - Move to ARMED when pre_cnt reaches P_lat.
  - ARMED:
    - Each valid sample is written at wptr; wptr++ with modulo-DEPTH wrap, overwriting the oldest data.
    - A valid sample with in_trig=1 is the trigger sample: it is written, trig_ptr = wptr, post_cnt = 1, out_triggered is set, and the state moves to POST.
    - If post_cnt = DEPTH - P_lat = 1, i.e. P = DEPTH-1, the state goes straight to DONE.
  - POST:
    - Each valid sample is written and post_cnt++.
    - When the write makes post_cnt = DEPTH - P_lat, set out_done and move to DONE.
    - in_trig is ignored.
  - DONE:
    - No writes.
    - in_rd_en → out_rd_data = RAM[(trig_ptr - P_lat + in_rd_addr) mod DEPTH]. Logical index P_lat is always the trigger sample.
    - Stays in DONE until in_arm or in_abort.
- in_arm from any state restarts the capture as from IDLE. A sample presented on the arm cycle is not captured.
- in_abort from any state → IDLE, and clears out_done and out_triggered. in_abort and in_arm in the same cycle: abort wins.
- Cycles with in_sample_valid=0 change nothing except the arm/abort handling.
- in_rd_en outside DONE → out_rd_valid=0 on the next cycle; out_rd_data holds its previous value.

## Timing
- Reset (async assert, sync release) → state IDLE, all outputs 0, all pointers and counters 0.
- out_busy is a combinational decode of the registered state. It is 1 from the cycle after in_arm until the cycle after the final write.
- out_triggered goes to 1 in the cycle after the trigger sample's clock edge.
- out_done goes to 1 in the cycle after the edge that writes the last sample. out_busy falls in the same cycle.
- Read latency is 1: in_rd_en at edge N gives out_rd_data and out_rd_valid=1 during cycle N+1. Reads are fully pipelined, one per cycle.
- Capture length is exactly DEPTH valid samples whenever at least P_lat valid samples precede the trigger. FILL guarantees this.
- Index arithmetic is ADDR_W-bit unsigned with natural wrap. post_cnt is ADDR_W+1 bits so it can represent DEPTH for P=0.

## Test plan
Bench uses DATA_W=8, ADDR_W=4 (DEPTH=16), with samples valid every cycle and counting 0,1,2,... unless stated.
- Reset mid-POST via in_rst_n pulse → all outputs 0 immediately; after release, in_rd_en gives out_rd_valid=0.
- P=4, in_trig on sample 10 → out_triggered the next cycle, out_done after sample 21. Reads 0..15 return 6..21, read 4 returns 10, each with 1-cycle latency.
- P=8, in_trig high on samples 3 (during FILL) and 20 → sample 3 is ignored. Buffer holds 12..27, read 8 returns 20.
- P=0, first sample 0x55 with in_trig=1 → read 0 returns 0x55. out_done after 16 samples.
- P=15, trigger on sample 40 with in_sample_valid toggling every other cycle → wrap exercised. Buffer holds 25..40, read 15 returns 40, out_done the cycle after the trigger edge.
- in_abort after 3 post samples → IDLE, out_busy=0, out_done=0. Then in_arm plus in_abort in the same cycle → stays IDLE. Re-arm with P=2 and trigger on sample 5 → buffer holds 3..18.
